// File: rtl/rca_config_loader_pkg.sv
// Shared types and defaults for the RCA configuration loader: header layout,
// target encoding and FSM states.
package rca_config;

  localparam int NUM_RCAS           = 4;
  localparam int NUM_READ_PORTS     = 4;
  localparam int NUM_WRITE_PORTS    = 2;
  localparam int NUM_GRID_MUXES     = 64;
  localparam int GRID_MUX_INPUTS    = 8;
  localparam int IO_UNIT_MUX_INPUTS = 8;
  localparam int GRID_NUM_ROWS      = 4;

  localparam int HDR_TARGET_LSB = 29;
  localparam int HDR_TARGET_W   = 3;
  localparam int HDR_RCA_LSB    = 24;
  localparam int HDR_RCA_W      = 5;
  localparam int HDR_START_LSB  = 12;
  localparam int HDR_START_W    = 12;
  localparam int HDR_CNT_LSB    = 0;
  localparam int HDR_CNT_W      = 12;

  typedef enum logic [2:0] {
    CPU_SRC  = 3'd0,
    CPU_DEST = 3'd1,
    GRID     = 3'd2,
    IO       = 3'd3,
    RESULT   = 3'd4
  } rca_cfg_target_t;

  // Target is kept raw so illegal encodings 5-7 survive the cast
  typedef struct packed {
    logic [HDR_TARGET_W-1:0] target;
    logic [HDR_RCA_W-1:0]    rca;
    logic [HDR_START_W-1:0]  start;
    logic [HDR_CNT_W-1:0]    n_m1;
  } rca_cfg_header_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } rca_cfg_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_config_loader_if.sv
// CPU-side configuration word channel (valid/ready).
interface rca_config_loader_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (output cfg_data, output cfg_valid, input  cfg_ready);
  modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/rca_config_hdr_check.sv
// Combinational legality check of a packet header: target encoding, RCA id
// and whether the requested index range fits the target table.
module rca_config_hdr_check
  import rca_config::*;
#(
  parameter int NUM_RCAS        = rca_config::NUM_RCAS,
  parameter int NUM_READ_PORTS  = rca_config::NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS = rca_config::NUM_WRITE_PORTS,
  parameter int NUM_GRID_MUXES  = rca_config::NUM_GRID_MUXES,
  parameter int GRID_NUM_ROWS   = rca_config::GRID_NUM_ROWS
) (
  input  rca_cfg_header_t i_hdr,
  output logic            o_legal
);

  logic        w_target_ok;
  logic [31:0] w_depth;
  logic [31:0] w_end;

  always_comb begin
    w_target_ok = 1'b1;
    w_depth     = 32'd0;
    case (i_hdr.target)
      CPU_SRC:  w_depth = 32'(NUM_READ_PORTS);
      CPU_DEST: w_depth = 32'(NUM_WRITE_PORTS);
      GRID:     w_depth = 32'(NUM_GRID_MUXES);
      IO:       w_depth = 32'(GRID_NUM_ROWS);
      RESULT:   w_depth = 32'(NUM_WRITE_PORTS);
      default:  w_target_ok = 1'b0;
    endcase
  end

  // start + N computed wide so a 12-bit start plus 4096 entries cannot wrap
  assign w_end   = 32'(i_hdr.start) + 32'(i_hdr.n_m1) + 32'd1;
  assign o_legal = w_target_ok
                && (32'(i_hdr.rca) < 32'(NUM_RCAS))
                && (w_end <= w_depth);

endmodule

// File: rtl/rca_config_loader.sv
// Turns header+payload configuration packets into single-cycle write strobes
// for the RCA configuration register file.
module rca_config_loader
  import rca_config::*;
#(
  parameter int NUM_RCAS           = rca_config::NUM_RCAS,
  parameter int NUM_READ_PORTS     = rca_config::NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS    = rca_config::NUM_WRITE_PORTS,
  parameter int NUM_GRID_MUXES     = rca_config::NUM_GRID_MUXES,
  parameter int GRID_MUX_INPUTS    = rca_config::GRID_MUX_INPUTS,
  parameter int IO_UNIT_MUX_INPUTS = rca_config::IO_UNIT_MUX_INPUTS,
  parameter int GRID_NUM_ROWS      = rca_config::GRID_NUM_ROWS,
  localparam int RCA_W    = idx_w(NUM_RCAS),
  localparam int PORT_W   = idx_w(NUM_READ_PORTS),
  localparam int GADDR_W  = idx_w(NUM_GRID_MUXES),
  localparam int GSEL_W   = idx_w(GRID_MUX_INPUTS),
  localparam int IOADDR_W = idx_w(GRID_NUM_ROWS),
  localparam int IOSEL_W  = idx_w(IO_UNIT_MUX_INPUTS),
  localparam int RADDR_W  = idx_w(NUM_WRITE_PORTS),
  localparam int RSEL_W   = idx_w(GRID_NUM_ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  rca_config_loader_if.slave  cfg,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [RCA_W-1:0]    rca_sel,
  output logic                cpu_reg_addr_wr_en,
  output logic [PORT_W-1:0]   cpu_port_sel,
  output logic                cpu_src_dest_port,
  output logic [4:0]          cpu_reg_addr,
  output logic                grid_mux_wr_en,
  output logic [GADDR_W-1:0]  grid_mux_addr,
  output logic [GSEL_W-1:0]   new_grid_mux_sel,
  output logic                io_mux_wr_en,
  output logic [IOADDR_W-1:0] io_mux_addr,
  output logic [IOSEL_W-1:0]  new_io_mux_sel,
  output logic                rca_result_mux_wr_en,
  output logic [RADDR_W-1:0]  rca_result_mux_addr,
  output logic [RSEL_W-1:0]   new_rca_result_mux_sel
);

  rca_cfg_state_t  r_state;
  rca_cfg_state_t  w_state_nxt;
  rca_cfg_header_t w_hdr;
  logic            w_hdr_legal;
  logic            w_hs;
  logic            w_last;
  logic [2:0]      r_target;
  logic [RCA_W-1:0] r_rca;
  logic [11:0]     r_count;
  logic [11:0]     r_index;

  assign w_hdr         = cfg.cfg_data;
  assign cfg.cfg_ready = 1'b1;
  assign w_hs          = cfg.cfg_valid & cfg.cfg_ready;
  assign w_last        = (r_count == 12'd0);

  rca_config_hdr_check #(
    .NUM_RCAS        (NUM_RCAS),
    .NUM_READ_PORTS  (NUM_READ_PORTS),
    .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
    .NUM_GRID_MUXES  (NUM_GRID_MUXES),
    .GRID_NUM_ROWS   (GRID_NUM_ROWS)
  ) u_hdr_check (
    .i_hdr   (w_hdr),
    .o_legal (w_hdr_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:  if (w_hs) w_state_nxt = w_hdr_legal ? ST_LOAD : ST_DRAIN;
      ST_LOAD:  if (w_hs && w_last) w_state_nxt = ST_IDLE;
      ST_DRAIN: if (w_hs && w_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered: payload handshake in t shows up as wr_en in t+1
  always_ff @(posedge clk) begin
    if (rst) begin
      done                   <= 1'b0;
      error                  <= 1'b0;
      r_target               <= 3'd0;
      r_rca                  <= '0;
      r_count                <= 12'd0;
      r_index                <= 12'd0;
      rca_sel                <= '0;
      cpu_reg_addr_wr_en     <= 1'b0;
      cpu_port_sel           <= '0;
      cpu_src_dest_port      <= 1'b0;
      cpu_reg_addr           <= 5'd0;
      grid_mux_wr_en         <= 1'b0;
      grid_mux_addr          <= '0;
      new_grid_mux_sel       <= '0;
      io_mux_wr_en           <= 1'b0;
      io_mux_addr            <= '0;
      new_io_mux_sel         <= '0;
      rca_result_mux_wr_en   <= 1'b0;
      rca_result_mux_addr    <= '0;
      new_rca_result_mux_sel <= '0;
    end else begin
      done                 <= 1'b0;
      cpu_reg_addr_wr_en   <= 1'b0;
      grid_mux_wr_en       <= 1'b0;
      io_mux_wr_en         <= 1'b0;
      rca_result_mux_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_hs) begin
          error    <= 1'b0;
          r_target <= w_hdr.target;
          r_rca    <= w_hdr.rca[RCA_W-1:0];
          r_count  <= w_hdr.n_m1;
          r_index  <= w_hdr.start;
        end
        ST_LOAD: if (w_hs) begin
          r_index <= r_index + 12'd1;
          r_count <= r_count - 12'd1;
          done    <= w_last;
          rca_sel <= r_rca;
          case (r_target)
            CPU_SRC, CPU_DEST: begin
              cpu_reg_addr_wr_en <= 1'b1;
              cpu_port_sel       <= r_index[PORT_W-1:0];
              cpu_src_dest_port  <= (r_target == CPU_DEST);
              cpu_reg_addr       <= cfg.cfg_data[4:0];
            end
            GRID: begin
              grid_mux_wr_en   <= 1'b1;
              grid_mux_addr    <= r_index[GADDR_W-1:0];
              new_grid_mux_sel <= cfg.cfg_data[GSEL_W-1:0];
            end
            IO: begin
              io_mux_wr_en   <= 1'b1;
              io_mux_addr    <= r_index[IOADDR_W-1:0];
              new_io_mux_sel <= cfg.cfg_data[IOSEL_W-1:0];
            end
            RESULT: begin
              rca_result_mux_wr_en   <= 1'b1;
              rca_result_mux_addr    <= r_index[RADDR_W-1:0];
              new_rca_result_mux_sel <= cfg.cfg_data[RSEL_W-1:0];
            end
            default: ;
          endcase
        end
        ST_DRAIN: if (w_hs) begin
          r_count <= r_count - 12'd1;
          if (w_last) begin
            done  <= 1'b1;
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_config_loader.sv
// Directed packets with a scoreboard queue of expected strobe/done events,
// popped by a negedge monitor whenever the loader presents one.
module tb_rca_config_loader;
  import rca_config::*;

  typedef struct packed {
    logic [2:0] kind;   // 0 done-only, 1 cpu, 2 grid, 3 io, 4 result
    logic [1:0] rca;
    logic       sd;
    logic [5:0] addr;
    logic [4:0] data;
    logic       dn;
    logic       err;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, done, error;
  logic [1:0] rca_sel;
  logic       cpu_reg_addr_wr_en;
  logic [1:0] cpu_port_sel;
  logic       cpu_src_dest_port;
  logic [4:0] cpu_reg_addr;
  logic       grid_mux_wr_en;
  logic [5:0] grid_mux_addr;
  logic [2:0] new_grid_mux_sel;
  logic       io_mux_wr_en;
  logic [1:0] io_mux_addr;
  logic [2:0] new_io_mux_sel;
  logic       rca_result_mux_wr_en;
  logic [0:0] rca_result_mux_addr;
  logic [1:0] new_rca_result_mux_sel;

  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  exp_q[$];

  rca_config_loader_if cfg_if ();

  rca_config_loader dut (
    .clk                    (clk),
    .rst                    (rst),
    .cfg                    (cfg_if),
    .busy                   (busy),
    .done                   (done),
    .error                  (error),
    .rca_sel                (rca_sel),
    .cpu_reg_addr_wr_en     (cpu_reg_addr_wr_en),
    .cpu_port_sel           (cpu_port_sel),
    .cpu_src_dest_port      (cpu_src_dest_port),
    .cpu_reg_addr           (cpu_reg_addr),
    .grid_mux_wr_en         (grid_mux_wr_en),
    .grid_mux_addr          (grid_mux_addr),
    .new_grid_mux_sel       (new_grid_mux_sel),
    .io_mux_wr_en           (io_mux_wr_en),
    .io_mux_addr            (io_mux_addr),
    .new_io_mux_sel         (new_io_mux_sel),
    .rca_result_mux_wr_en   (rca_result_mux_wr_en),
    .rca_result_mux_addr    (rca_result_mux_addr),
    .new_rca_result_mux_sel (new_rca_result_mux_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic ev_t mk(input int kind, input int rca, input int sd, input int addr,
                             input int data, input int dn, input int err);
    ev_t e;
    e.kind = 3'(kind); e.rca = 2'(rca); e.sd = 1'(sd); e.addr = 6'(addr);
    e.data = 5'(data); e.dn = 1'(dn); e.err = 1'(err);
    return e;
  endfunction

  // Monitor: every strobe or done pulse must match the next queued event
  always @(negedge clk) begin
    if (!rst && (cpu_reg_addr_wr_en || grid_mux_wr_en || io_mux_wr_en
                 || rca_result_mux_wr_en || done)) begin
      int  nstb;
      ev_t act, exp;
      nstb = int'(cpu_reg_addr_wr_en) + int'(grid_mux_wr_en) + int'(io_mux_wr_en)
           + int'(rca_result_mux_wr_en);
      act = mk(0, 0, 0, 0, 0, int'(done), int'(error));
      if (cpu_reg_addr_wr_en)
        act = mk(1, int'(rca_sel), int'(cpu_src_dest_port), int'(cpu_port_sel),
                 int'(cpu_reg_addr), int'(done), int'(error));
      else if (grid_mux_wr_en)
        act = mk(2, int'(rca_sel), 0, int'(grid_mux_addr), int'(new_grid_mux_sel),
                 int'(done), int'(error));
      else if (io_mux_wr_en)
        act = mk(3, int'(rca_sel), 0, int'(io_mux_addr), int'(new_io_mux_sel),
                 int'(done), int'(error));
      else if (rca_result_mux_wr_en)
        act = mk(4, int'(rca_sel), 0, int'(rca_result_mux_addr),
                 int'(new_rca_result_mux_sel), int'(done), int'(error));
      if (nstb > 1) chk("one_strobe", 64'(nstb), 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'(act), 64'd0);
      end else begin
        exp = exp_q.pop_front();
        chk("event", 64'(act), 64'(exp));
      end
    end
  end

  task automatic send(input logic [31:0] w);
    cfg_if.cfg_data  = w;
    cfg_if.cfg_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cfg_if.cfg_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_err", 64'({done, error}), 64'd0);
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
    chk("rst_strobes", 64'({cpu_reg_addr_wr_en, grid_mux_wr_en, io_mux_wr_en,
                            rca_result_mux_wr_en}), 64'd0);
    chk("rst_outputs", {rca_sel, cpu_port_sel, cpu_src_dest_port, cpu_reg_addr,
                        grid_mux_addr, new_grid_mux_sel, io_mux_addr, new_io_mux_sel,
                        rca_result_mux_addr, new_rca_result_mux_sel}, 64'd0);
    rst = 1'b0;

    // Grid, back-to-back payloads
    exp_q.push_back(mk(2, 0, 0, 5, 3, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 6, 7, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 7, 1, 1, 0));
    send(32'h4000_5002);
    chk("grid_busy", 64'(busy), 64'd1);
    send(32'd3); send(32'd7); send(32'd1);
    idle(2);
    chk("grid_idle", 64'(busy), 64'd0);

    // CPU dest
    exp_q.push_back(mk(1, 2, 1, 1, 31, 1, 0));
    send(32'h2200_1000); send(32'h0000_001F);
    idle(2);

    // Overflow on cpu src: 3+2 > 4
    send(32'h0000_3001); send(32'h0000_00AA);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    send(32'h0000_00BB);
    idle(1);
    chk("ovf_error", 64'(error), 64'd1);
    send(32'h0100_0000);
    chk("ovf_clear", 64'(error), 64'd0);
    exp_q.push_back(mk(1, 1, 0, 0, 5, 1, 0));
    send(32'h0000_0025);
    idle(2);

    // Illegal target, then illegal rca id
    send(32'hC000_0000);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    send(32'h0000_0001);
    idle(1);
    chk("bad_target_err", 64'(error), 64'd1);
    send(32'h4400_0000);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    send(32'h0000_0002);
    idle(1);
    chk("bad_rca_err", 64'(error), 64'd1);

    // Result target with a stall between payloads
    send(32'h8100_0001);
    exp_q.push_back(mk(4, 1, 0, 0, 2, 0, 0));
    send(32'd2);
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_busy%0d", i), 64'(busy), 64'd1);
    end
    exp_q.push_back(mk(4, 1, 0, 1, 3, 1, 0));
    send(32'd3);
    idle(2);
    chk("stall_end_busy", 64'(busy), 64'd0);

    // Range edges: last grid mux, last io mux, grid one past the end
    exp_q.push_back(mk(2, 0, 0, 63, 5, 1, 0));
    send(32'h4003_F000); send(32'h0000_00FD);
    exp_q.push_back(mk(3, 0, 0, 3, 7, 1, 0));
    send(32'h6000_3000); send(32'h0000_0007);
    send(32'h4003_F001); send(32'd1);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    send(32'd2);
    idle(1);

    // Reset in the middle of a 3-word grid packet
    exp_q.push_back(mk(2, 0, 0, 0, 4, 0, 0));
    send(32'h4000_0002); send(32'd4);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(error), 64'd0);
    idle(2);
    send(32'h6000_0000);
    chk("resync_busy", 64'(busy), 64'd1);
    exp_q.push_back(mk(3, 0, 0, 0, 6, 1, 0));
    send(32'd6);
    idle(3);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rca_config_loader.md
Name: rca_config_loader

Overview:
- Streaming writer that converts configuration packets from the CPU-side config channel into single-cycle write strobes for the RCA configuration register file.
- Targets: CPU source/destination register address tables, grid crossbar selects, IO-unit crossbar selects, and result crossbar selects.
- Sits between the config-issue logic in the RCA unit and the config register file. It is the only agent that drives that register file's write interface.

Parameters:
- NUM_RCAS, default rca_config::NUM_RCAS (4): number of RCAs.
- NUM_READ_PORTS, default rca_config::NUM_READ_PORTS (4): CPU source ports per RCA.
- NUM_WRITE_PORTS, default rca_config::NUM_WRITE_PORTS (2): CPU destination ports per RCA.
- NUM_GRID_MUXES, default rca_config::NUM_GRID_MUXES (64): grid crossbar mux count.
- GRID_MUX_INPUTS, default rca_config::GRID_MUX_INPUTS (8): inputs per grid mux.
- IO_UNIT_MUX_INPUTS, default rca_config::IO_UNIT_MUX_INPUTS (8): inputs per IO mux.
- GRID_NUM_ROWS, default rca_config::GRID_NUM_ROWS (4): grid rows; this is both the IO mux count and the result-select width source.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_data  in  32  packet word
- cfg_valid  in  1  word valid
- cfg_ready  out  1  word accepted when cfg_valid & cfg_ready
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse after the last write of a packet
- error  out  1  sticky; bad header on the last packet
- rca_sel  out  clog2(NUM_RCAS)  RCA index
- cpu_reg_addr_wr_en  out  1  strobe
- cpu_port_sel  out  clog2(NUM_READ_PORTS)  port index
- cpu_src_dest_port  out  1  0 = src, 1 = dest
- cpu_reg_addr  out  5  CPU register number
- grid_mux_wr_en  out  1  strobe
- grid_mux_addr  out  clog2(NUM_GRID_MUXES)  mux index
- new_grid_mux_sel  out  clog2(GRID_MUX_INPUTS)  select value
- io_mux_wr_en  out  1  strobe
- io_mux_addr  out  clog2(GRID_NUM_ROWS)  mux index
- new_io_mux_sel  out  clog2(IO_UNIT_MUX_INPUTS)  select value
- rca_result_mux_wr_en  out  1  strobe
- rca_result_mux_addr  out  clog2(NUM_WRITE_PORTS)  mux index
- new_rca_result_mux_sel  out  clog2(GRID_NUM_ROWS)  select value

Behaviour:
- Packet format: one header word, then N payload words.
- Header fields:
  - [31:29] target: 0 = cpu src, 1 = cpu dest, 2 = grid, 3 = io, 4 = result; 5-7 are illegal.
  - [28:24] rca id.
  - [23:12] start index.
  - [11:0] N-1.
- Payload: the entry value sits in the low bits, zero-extended; unused upper bits are ignored.
- Target depths:
  - cpu src: NUM_READ_PORTS.
  - cpu dest: NUM_WRITE_PORTS.
  - grid: NUM_GRID_MUXES.
  - io: GRID_NUM_ROWS.
  - result: NUM_WRITE_PORTS.
- FSM states:
  - IDLE: cfg_ready=1. A header handshake clears error, latches the header, and loads count=N-1 and index=start. Header legal -> LOAD; illegal -> DRAIN.
  - A header is illegal if the target is illegal, OR rca id >= NUM_RCAS, OR start+N > depth of the target.
  - LOAD: cfg_ready=1. Each payload handshake registers exactly one write; index += 1; count -= 1. The handshake at count==0 -> IDLE.
  - DRAIN: cfg_ready=1. Payload words are consumed with no strobes. The handshake at count==0 -> IDLE and sets error=1.
- Write latency:
  - Payload handshake in cycle t -> matching wr_en high in cycle t+1 for exactly one cycle, with addr, data, rca_sel and cpu_src_dest_port valid in t+1.
  - At most one wr_en is high per cycle.
- Payload handshakes on consecutive cycles give back-to-back strobes at 1 write/cycle.
- cfg_valid low mid-packet stalls indefinitely; there is no timeout and no strobe is issued.
- done pulses in cycle t+1 after the final payload handshake (also after DRAIN), aligned with the last strobe.
- busy = state != IDLE.
- Address/data outputs hold their last value between strobes; consumers sample them only with wr_en.
- Index never wraps: the range check at header time guarantees start+N <= depth.
- Reset:
  - All strobes, busy, done and error are 0; all address/data outputs are 0; state is IDLE; cfg_ready=1.
  - Reset mid-packet abandons the packet and issues no pending strobe. The next accepted word is parsed as a header; software re-syncs.

Decomposition:
- rca_config package holds:
  - rca_cfg_target_t enum (CPU_SRC, CPU_DEST, GRID, IO, RESULT).
  - The header field-position localparams.
  - An rca_cfg_header_t packed struct.
- One natural sub-module, rca_config_hdr_check: combinational legality and depth check on the header fields.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Grid write, valid every cycle: header {2, 0, start=5, N-1=2}, payloads 3, 7, 1 -> grid_mux_wr_en high 3 consecutive cycles with (addr, sel) = (5,3), (6,7), (7,1); done is high alongside the third strobe.
- CPU dest: header {1, rca=2, start=1, N-1=0}, payload 0x1F -> one cycle with cpu_reg_addr_wr_en=1, rca_sel=2, cpu_src_dest_port=1, cpu_port_sel=1, cpu_reg_addr=31.
- Overflow: header {0, 0, start=3, N-1=1} (3+2 > 4) -> 2 payload words consumed, no strobes, error=1 after the second; a following legal header clears error.
- Illegal target/rca: header target=6 with N-1=0, then header rca=4 -> each drains one word; error=1, and wr_en stays 0 throughout.
- Back-pressure: result header {4, 1, 0, N-1=1}, 5 idle cycles between the payloads -> exactly two strobes at addr 0 then 1; busy stays high across the gap.
- Reset mid-packet: rst after 1 of 3 grid payloads -> no further strobes, busy=0; the next word 0x6000_0000 is treated as header {3, 0, 0, 0}.
